// File: rtl/func_pool_scheduler.sv
// Round-robin scheduler sharing NINST identical HLS child instances between PARENT callers.
// Optional per-instance watchdog enabled by defining FUNC_POOL_TIMEOUT_EN.
module func_pool_scheduler #(
    parameter int PARENT     = 4,
    parameter int NINST      = 4,
    parameter int ARG_DW     = 64,
    parameter int LOG_PARENT = (PARENT == 1) ? 1 : $clog2(PARENT),
    parameter int LOG_INST   = (NINST == 1) ? 1 : $clog2(NINST),
    parameter int TIMEOUT_W  = 16,
    localparam int CNT_W     = $clog2(NINST + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [PARENT-1:0]        req_vld_i,
    output logic [PARENT-1:0]        req_rdy_o,
    input  logic [PARENT*ARG_DW-1:0] req_args_i,
    output logic [NINST-1:0]         inst_start_o,
    output logic [NINST-1:0]         inst_ce_o,
    output logic [ARG_DW-1:0]        inst_args_o,
    output logic [LOG_PARENT-1:0]    inst_parent_o,
    input  logic [NINST-1:0]         inst_done_i,
    output logic                     grant_vld_o,
    output logic [LOG_PARENT-1:0]    grant_parent_o,
    output logic [LOG_INST-1:0]      grant_inst_o,
    output logic [CNT_W-1:0]         busy_cnt_o,
    input  logic [TIMEOUT_W-1:0]     timeout_cyc_i,
    output logic                     timeout_o,
    output logic [LOG_INST-1:0]      timeout_inst_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } inst_state_t;

    inst_state_t                 r_state     [NINST];
    inst_state_t                 w_state_nxt [NINST];
    logic [NINST-1:0]            w_free;
    logic [NINST-1:0]            w_expire;
    logic [LOG_INST-1:0]         w_alloc;
    logic                        w_any_free;
    logic [LOG_PARENT-1:0]       w_sel;
    logic                        w_sel_vld;
    logic [LOG_PARENT-1:0]       w_sel_hi;
    logic                        w_sel_hi_vld;
    logic [LOG_PARENT-1:0]       w_sel_lo;
    logic                        w_sel_lo_vld;
    logic [ARG_DW-1:0]           w_sel_args;
    logic                        w_accept;
    logic [CNT_W-1:0]            w_busy_nxt;

    logic [LOG_PARENT-1:0]       r_rr;
    logic [ARG_DW-1:0]           r_args;
    logic [LOG_PARENT-1:0]       r_parent;
    logic                        r_grant_vld;
    logic [LOG_PARENT-1:0]       r_grant_parent;
    logic [LOG_INST-1:0]         r_grant_inst;
    logic [CNT_W-1:0]            r_busy_cnt;

    // Lowest-index free instance, taken from registered state only.
    always_comb begin
        w_free  = '0;
        w_alloc = '0;
        for (int i = NINST - 1; i >= 0; i--) begin
            w_free[i] = (r_state[i] == ST_IDLE);
            if (r_state[i] == ST_IDLE) w_alloc = LOG_INST'(i);
        end
        w_any_free = |w_free;
    end

    // Cyclic search from rr: first requester at or above rr, else the lowest requester.
    always_comb begin
        w_sel_hi     = '0;
        w_sel_hi_vld = 1'b0;
        w_sel_lo     = '0;
        w_sel_lo_vld = 1'b0;
        for (int p = PARENT - 1; p >= 0; p--) begin
            if (req_vld_i[p]) begin
                w_sel_lo     = LOG_PARENT'(p);
                w_sel_lo_vld = 1'b1;
                if (p >= int'(r_rr)) begin
                    w_sel_hi     = LOG_PARENT'(p);
                    w_sel_hi_vld = 1'b1;
                end
            end
        end
        w_sel     = w_sel_hi_vld ? w_sel_hi : w_sel_lo;
        w_sel_vld = w_sel_lo_vld;
    end

    // NOTE: rdy is combinational and already qualified by vld, so accept needs no extra gating.
    always_comb begin
        req_rdy_o  = '0;
        w_sel_args = '0;
        for (int p = 0; p < PARENT; p++) begin
            if (p == int'(w_sel)) begin
                req_rdy_o[p] = w_sel_vld & w_any_free;
                w_sel_args   = req_args_i[p*ARG_DW +: ARG_DW];
            end
        end
        w_accept = w_sel_vld & w_any_free;
    end

    always_comb begin
        w_busy_nxt = '0;
        for (int i = 0; i < NINST; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ST_IDLE:  if (w_accept && (int'(w_alloc) == i)) w_state_nxt[i] = ST_START;
                ST_START: w_state_nxt[i] = ST_RUN;
                ST_RUN:   if (inst_done_i[i] || w_expire[i]) w_state_nxt[i] = ST_IDLE;
                default:  w_state_nxt[i] = ST_IDLE;
            endcase
            if (w_state_nxt[i] != ST_IDLE) w_busy_nxt = w_busy_nxt + CNT_W'(1);
        end
    end

    // NOTE: the per-instance state array is reset explicitly; ce must drop the moment rstn falls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NINST; i++) r_state[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < NINST; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr           <= '0;
            r_args         <= '0;
            r_parent       <= '0;
            r_grant_vld    <= 1'b0;
            r_grant_parent <= '0;
            r_grant_inst   <= '0;
            r_busy_cnt     <= '0;
        end else begin
            r_grant_vld <= w_accept;
            r_busy_cnt  <= w_busy_nxt;
            if (w_accept) begin
                r_rr           <= (int'(w_sel) == PARENT - 1) ? '0 : w_sel + 1'b1;
                r_args         <= w_sel_args;
                r_parent       <= w_sel;
                r_grant_parent <= w_sel;
                r_grant_inst   <= w_alloc;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NINST; i++) begin
            inst_start_o[i] = (r_state[i] == ST_START);
            inst_ce_o[i]    = (r_state[i] == ST_START) || (r_state[i] == ST_RUN);
        end
    end

    assign inst_args_o    = r_args;
    assign inst_parent_o  = r_parent;
    assign grant_vld_o    = r_grant_vld;
    assign grant_parent_o = r_grant_parent;
    assign grant_inst_o   = r_grant_inst;
    assign busy_cnt_o     = r_busy_cnt;

`ifdef FUNC_POOL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_wd_cnt [NINST];
    logic                 r_timeout;
    logic [LOG_INST-1:0]  r_timeout_inst;
    logic [LOG_INST-1:0]  w_to_inst;

    // Expiry when the count would reach 0 this RUN cycle; a load of 0 never expires.
    always_comb begin
        w_to_inst = '0;
        for (int i = NINST - 1; i >= 0; i--) begin
            w_expire[i] = (r_state[i] == ST_RUN) && (r_wd_cnt[i] == TIMEOUT_W'(1)) && !inst_done_i[i];
            if (w_expire[i]) w_to_inst = LOG_INST'(i);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NINST; i++) r_wd_cnt[i] <= '0;
            r_timeout      <= 1'b0;
            r_timeout_inst <= '0;
        end else begin
            for (int i = 0; i < NINST; i++) begin
                if (w_accept && (int'(w_alloc) == i)) r_wd_cnt[i] <= timeout_cyc_i;
                else if ((r_state[i] == ST_RUN) && (r_wd_cnt[i] != '0)) r_wd_cnt[i] <= r_wd_cnt[i] - 1'b1;
            end
            r_timeout <= |w_expire;
            if (|w_expire) r_timeout_inst <= w_to_inst;
        end
    end

    assign timeout_o      = r_timeout;
    assign timeout_inst_o = r_timeout_inst;
`else
    logic w_unused_timeout;

    assign w_expire         = '0;
    assign w_unused_timeout = ^timeout_cyc_i;
    assign timeout_o        = 1'b0;
    assign timeout_inst_o   = '0;
`endif

endmodule

// File: tb/tb_func_pool_scheduler.sv
// Scoreboard bench for func_pool_scheduler: directed calls push expected grants, a negedge monitor pops them.
module tb_func_pool_scheduler;
    localparam int PARENT = 4;
    localparam int NINST  = 4;
    localparam int ARG_DW = 64;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic [PARENT-1:0]        req_vld_i = '0;
    logic [PARENT-1:0]        req_rdy_o;
    logic [PARENT*ARG_DW-1:0] req_args_i;
    logic [NINST-1:0]         inst_start_o;
    logic [NINST-1:0]         inst_ce_o;
    logic [ARG_DW-1:0]        inst_args_o;
    logic [1:0]               inst_parent_o;
    logic [NINST-1:0]         inst_done_i = '0;
    logic                     grant_vld_o;
    logic [1:0]               grant_parent_o;
    logic [1:0]               grant_inst_o;
    logic [2:0]               busy_cnt_o;
    logic [15:0]              timeout_cyc_i = '0;
    logic                     timeout_o;
    logic [1:0]               timeout_inst_o;

    logic [ARG_DW-1:0] args [PARENT];

    typedef struct {
        logic [1:0]        parent;
        logic [1:0]        inst;
        logic [ARG_DW-1:0] data;
    } grant_t;

    grant_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < PARENT; p++) req_args_i[p*ARG_DW +: ARG_DW] = args[p];
    end

    func_pool_scheduler dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_vld_i      (req_vld_i),
        .req_rdy_o      (req_rdy_o),
        .req_args_i     (req_args_i),
        .inst_start_o   (inst_start_o),
        .inst_ce_o      (inst_ce_o),
        .inst_args_o    (inst_args_o),
        .inst_parent_o  (inst_parent_o),
        .inst_done_i    (inst_done_i),
        .grant_vld_o    (grant_vld_o),
        .grant_parent_o (grant_parent_o),
        .grant_inst_o   (grant_inst_o),
        .busy_cnt_o     (busy_cnt_o),
        .timeout_cyc_i  (timeout_cyc_i),
        .timeout_o      (timeout_o),
        .timeout_inst_o (timeout_inst_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int p, input int i);
        grant_t g;
        g.parent = 2'(p);
        g.inst   = 2'(i);
        g.data   = args[p];
        exp_q.push_back(g);
    endtask

    // Frees every instance; the first tick lets any START instance reach RUN.
    task automatic release_all();
        tick();
        inst_done_i = '1;
        tick();
        inst_done_i = '0;
        #1;
        check("release_busy", 64'(busy_cnt_o), 64'd0);
        check("release_ce", 64'(inst_ce_o), 64'd0);
    endtask

    // Monitor: every grant pulse must match the oldest expected grant.
    always @(negedge clk) begin
        if (rstn) begin
`ifndef FUNC_POOL_TIMEOUT_EN
            check("timeout_tied_low", 64'(timeout_o), 64'd0);
`endif
            if (grant_vld_o) begin
                if (exp_q.size() == 0) begin
                    check("grant_unexpected", 64'(grant_vld_o), 64'd0);
                end else begin
                    grant_t g;
                    g = exp_q.pop_front();
                    check("grant_parent", 64'(grant_parent_o), 64'(g.parent));
                    check("grant_inst", 64'(grant_inst_o), 64'(g.inst));
                    check("inst_parent", 64'(inst_parent_o), 64'(g.parent));
                    check("inst_args", inst_args_o, g.data);
                    check("inst_start_onehot", 64'(inst_start_o), 64'd1 << g.inst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < PARENT; p++) args[p] = 64'(p * 32'h11);

        // Reset state
        #12;
        check("reset_ce", 64'(inst_ce_o), 64'd0);
        check("reset_start", 64'(inst_start_o), 64'd0);
        check("reset_busy", 64'(busy_cnt_o), 64'd0);
        check("reset_grant_vld", 64'(grant_vld_o), 64'd0);
        check("reset_timeout", 64'(timeout_o), 64'd0);
        check("reset_rdy", 64'(req_rdy_o), 64'd0);
        rstn = 1'b1;
        tick();

        // All four callers at once: consecutive grants p0..p3 to inst 0..3
        req_vld_i = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_all_rdy", 64'(req_rdy_o), 64'd1 << k);
            expect_grant(k, k);
            tick();
            req_vld_i[k] = 1'b0;
        end
        #1;
        check("all_busy_cnt", 64'(busy_cnt_o), 64'd4);
        check("all_busy_ce", 64'(inst_ce_o), 64'hF);

        // Pool full, caller 2 waiting; done[1] only frees the slot next cycle
        args[2]   = 64'hDEAD_BEEF_0000_0002;
        req_vld_i = 4'b0100;
        #1;
        check("rdy_pool_full", 64'(req_rdy_o), 64'd0);
        tick();
        inst_done_i = 4'b0010;
        #1;
        check("rdy_same_cycle_done", 64'(req_rdy_o[2]), 64'd0);
        expect_grant(2, 1);
        tick();
        inst_done_i = '0;
        #1;
        check("rdy_after_done", 64'(req_rdy_o), 64'b0100);
        check("busy_after_done", 64'(busy_cnt_o), 64'd3);
        tick();
        req_vld_i = '0;
        #1;
        check("start_reused_inst1", 64'(inst_start_o), 64'b0010);
        check("busy_refilled", 64'(busy_cnt_o), 64'd4);
        release_all();

        // Caller 3 repeatedly (rr wraps to 0), then caller 1 joins and is served first
        args[3]   = 64'h3333_0000_0000_0003;
        req_vld_i = 4'b1000;
        for (int j = 0; j < 2; j++) begin
            #1;
            check("rdy_p3_repeat", 64'(req_rdy_o), 64'b1000);
            expect_grant(3, j);
            tick();
        end
        req_vld_i = 4'b1010;
        #1;
        check("rdy_p1_not_starved", 64'(req_rdy_o), 64'b0010);
        expect_grant(1, 2);
        tick();
        req_vld_i = 4'b1000;
        #1;
        check("rdy_p3_after_p1", 64'(req_rdy_o), 64'b1000);
        expect_grant(3, 3);
        tick();
        #1;
        check("rdy_full_again", 64'(req_rdy_o), 64'd0);
        check("busy_full_again", 64'(busy_cnt_o), 64'd4);
        req_vld_i = '0;
        release_all();

        // done during START ignored; done on an IDLE instance ignored
        req_vld_i = 4'b0001;
        #1;
        check("rdy_p0", 64'(req_rdy_o), 64'b0001);
        expect_grant(0, 0);
        tick();
        req_vld_i   = '0;
        inst_done_i = 4'b0001;
        tick();
        inst_done_i = '0;
        #1;
        check("done_in_start_ce", 64'(inst_ce_o), 64'b0001);
        check("done_in_start_busy", 64'(busy_cnt_o), 64'd1);
        inst_done_i = 4'b0100;
        tick();
        inst_done_i = '0;
        #1;
        check("done_idle_busy", 64'(busy_cnt_o), 64'd1);
        check("done_idle_ce", 64'(inst_ce_o), 64'b0001);

        // Three instances running, then async reset mid-call
        req_vld_i = 4'b0110;
        #1;
        check("rdy_p1", 64'(req_rdy_o), 64'b0010);
        expect_grant(1, 1);
        tick();
        req_vld_i = 4'b0100;
        #1;
        check("rdy_p2", 64'(req_rdy_o), 64'b0100);
        expect_grant(2, 2);
        tick();
        req_vld_i = '0;
        tick();
        check("three_busy", 64'(busy_cnt_o), 64'd3);
        check("three_ce", 64'(inst_ce_o), 64'b0111);
        rstn = 1'b0;
        #1;
        check("async_reset_ce", 64'(inst_ce_o), 64'd0);
        check("async_reset_busy", 64'(busy_cnt_o), 64'd0);
        tick();
        rstn      = 1'b1;
        req_vld_i = 4'b0100;
        #1;
        check("rdy_after_reset", 64'(req_rdy_o), 64'b0100);
        expect_grant(2, 0);
        tick();
        req_vld_i = '0;
        release_all();

`ifdef FUNC_POOL_TIMEOUT_EN
        // Watchdog: load 8, no done -> expiry 9 cycles after the start cycle
        begin
            int cyc;
            timeout_cyc_i = 16'd8;
            req_vld_i     = 4'b0001;
            #1;
            expect_grant(0, 0);
            tick();
            req_vld_i = '0;
            cyc = 0;
            while (!timeout_o && cyc < 20) begin
                tick();
                cyc++;
            end
            check("timeout_latency", 64'(cyc), 64'd9);
            check("timeout_inst", 64'(timeout_inst_o), 64'd0);
            check("timeout_ce_drop", 64'(inst_ce_o[0]), 64'd0);
            timeout_cyc_i = '0;
            req_vld_i     = 4'b0001;
            #1;
            check("timeout_reuse_rdy", 64'(req_rdy_o), 64'b0001);
            expect_grant(0, 0);
            tick();
            req_vld_i = '0;
            release_all();
        end
`endif

        repeat (3) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
